// File: rtl/cosim_cycle_count_pkg.sv
// -----------------------------------------------------------------------------
// cosim_cycle_count_pkg
// Shared types for the cycle-count request/response initiator.
//   resp_t      : 128-bit response payload, cycle in the upper 64 bits,
//                 frequency (Hz) in the lower 64 bits.
//   state_t     : requester FSM states.
//   RESP_BITS   : width of the packed response payload.
//   cycle_delta : elapsed cycles between two samples, modulo 2^64.
// -----------------------------------------------------------------------------
package cosim_cycle_count_pkg;

    localparam int RESP_BITS = 128;

    typedef struct packed {
        longint unsigned cycle;
        longint unsigned freq;
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // The very first sample has no predecessor, so its delta is defined as 0.
    function automatic logic [63:0] cycle_delta(input logic        first,
                                                input logic [63:0] new_cycle,
                                                input logic [63:0] old_cycle);
        return first ? 64'd0 : (new_cycle - old_cycle);
    endfunction

endpackage

// File: rtl/cosim_cycle_count_period_timer.sv
// -----------------------------------------------------------------------------
// cosim_cycle_count_period_timer
// Reloadable down-counter. Loads RELOAD on reset and whenever load is high,
// otherwise decrements while enable is high and stops at 0. expired is high
// while the count equals 1, i.e. in the last cycle of the interval.
// RELOAD = 0 parks the counter at 0 so expired never fires.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   load    : reload the counter (takes precedence over enable)
//   enable  : count down this cycle
//   expired : last cycle of the interval
// -----------------------------------------------------------------------------
module cosim_cycle_count_period_timer #(
    parameter int unsigned RELOAD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create order races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RELOAD;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable && count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign expired = (count == 32'd1);

endmodule

// File: rtl/cosim_cycle_count_requester.sv
// -----------------------------------------------------------------------------
// cosim_cycle_count_requester
// Hardware-side initiator for the cycle-count protocol. Sends a 1-bit request
// on a valid/ready channel (on trigger or periodically), accepts a 128-bit
// {cycle, freq} response, latches it and reports the elapsed cycle count since
// the previous sample.
//   clk, rst                     : clock, asynchronous active-high reset
//   trigger                      : one-cycle request for a sample
//   req_valid/req_ready/req_data : request channel (payload always 0)
//   resp_valid/resp_ready        : response channel handshake
//   resp_data                    : {cycle[127:64], freq[63:0]}
//   sample_valid                 : one-cycle pulse when a sample is latched
//   sample_cycle/freq/delta      : latched sample and cycle delta
//   sample_first                 : latched sample is the first since reset
//   busy                         : request or wait in progress
//   timeout_pulse/timeout_err    : abort pulse and sticky abort flag
//   drop_count                   : saturating count of stale responses
// -----------------------------------------------------------------------------
module cosim_cycle_count_requester
    import cosim_cycle_count_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int          DROP_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_data,
    input  logic                  resp_valid,
    output logic                  resp_ready,
    input  logic [RESP_BITS-1:0]  resp_data,
    output logic                  sample_valid,
    output logic [63:0]           sample_cycle,
    output logic [63:0]           sample_freq,
    output logic [63:0]           sample_delta,
    output logic                  sample_first,
    output logic                  busy,
    output logic                  timeout_pulse,
    output logic                  timeout_err,
    output logic [DROP_CNT_W-1:0] drop_count
);

    // Reset asserts immediately but releases on a clock edge, so no flop
    // leaves reset in a different cycle from its neighbours.
    logic [1:0] rst_sync;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_int = rst_sync[1];

    state_t state, state_nxt;
    resp_t  resp;
    logic   pending;
    logic   first_flag;
    logic   period_exp;
    logic   tmo_exp;
    logic   go_req;
    logic   enter_req;
    logic   resp_fire;
    logic   capture;
    logic   abort;
    logic   drop;

    assign resp     = resp_t'(resp_data);
    assign req_data = 1'b0;

    cosim_cycle_count_period_timer #(.RELOAD(PERIOD_CYCLES)) u_period (
        .clk     (clk),
        .rst     (rst_int),
        .load    (enter_req),
        .enable  (1'b1),
        .expired (period_exp)
    );

    cosim_cycle_count_period_timer #(.RELOAD(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst_int),
        .load    (enter_req),
        .enable  (state != IDLE),
        .expired (tmo_exp)
    );

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        enter_req = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        go_req    = trigger || pending || period_exp;
        resp_fire = resp_valid && resp_ready;
        case (state)
            IDLE: begin
                if (go_req) begin
                    state_nxt = REQ;
                    enter_req = 1'b1;
                end
            end
            REQ: begin
                // A responder may answer in the same cycle it accepts.
                if (req_ready && resp_fire) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_exp) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (resp_fire) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_exp) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Anything accepted that does not answer an outstanding request is stale.
        drop = resp_fire && !capture;
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state         <= IDLE;
            req_valid     <= 1'b0;
            resp_ready    <= 1'b0;
            busy          <= 1'b0;
            pending       <= 1'b0;
            first_flag    <= 1'b1;
            sample_valid  <= 1'b0;
            sample_cycle  <= 64'd0;
            sample_freq   <= 64'd0;
            sample_delta  <= 64'd0;
            sample_first  <= 1'b0;
            timeout_pulse <= 1'b0;
            timeout_err   <= 1'b0;
            drop_count    <= '0;
        end else begin
            state      <= state_nxt;
            // Outputs follow the next state so they are registered yet aligned
            // with the state they describe.
            req_valid  <= (state_nxt == REQ);
            busy       <= (state_nxt != IDLE);
            resp_ready <= 1'b1;

            // Requests that arrive while busy coalesce into one; leaving IDLE
            // consumes it.
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (trigger || period_exp) begin
                pending <= 1'b1;
            end

            sample_valid <= capture;
            if (capture) begin
                sample_cycle <= resp.cycle;
                sample_freq  <= resp.freq;
                sample_delta <= cycle_delta(first_flag, resp.cycle, sample_cycle);
                sample_first <= first_flag;
                first_flag   <= 1'b0;
            end

            timeout_pulse <= abort;
            if (abort) begin
                timeout_err <= 1'b1;
            end

            if (drop && drop_count != '1) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cosim_cycle_count_requester.sv
module tb_cosim_cycle_count_requester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: on-demand requests, short timeout ----------------
    logic         a_rst, a_trigger, a_req_valid, a_req_ready, a_req_data;
    logic         a_resp_valid, a_resp_ready;
    logic [127:0] a_resp_data;
    logic         a_sample_valid, a_sample_first, a_busy;
    logic [63:0]  a_sample_cycle, a_sample_freq, a_sample_delta;
    logic         a_timeout_pulse, a_timeout_err;
    logic [7:0]   a_drop_count;
    logic         comb_mode, man_req_ready, man_resp_valid;
    int           a_cyc = 0;

    // Combinational responder: accepts whenever it can answer, answers at once.
    assign a_req_ready  = comb_mode ? a_resp_ready : man_req_ready;
    assign a_resp_valid = comb_mode ? a_req_valid  : man_resp_valid;

    cosim_cycle_count_requester #(
        .PERIOD_CYCLES (0),
        .TIMEOUT_CYCLES(8),
        .DROP_CNT_W    (8)
    ) dut_a (
        .clk          (clk),
        .rst          (a_rst),
        .trigger      (a_trigger),
        .req_valid    (a_req_valid),
        .req_ready    (a_req_ready),
        .req_data     (a_req_data),
        .resp_valid   (a_resp_valid),
        .resp_ready   (a_resp_ready),
        .resp_data    (a_resp_data),
        .sample_valid (a_sample_valid),
        .sample_cycle (a_sample_cycle),
        .sample_freq  (a_sample_freq),
        .sample_delta (a_sample_delta),
        .sample_first (a_sample_first),
        .busy         (a_busy),
        .timeout_pulse(a_timeout_pulse),
        .timeout_err  (a_timeout_err),
        .drop_count   (a_drop_count)
    );

    always @(posedge clk) begin
        if (a_rst) a_cyc <= 0;
        else       a_cyc <= a_cyc + 1;
    end

    // ---------------- DUT P: periodic requests, stalling responder -----------
    logic         p_rst = 1'b1;
    logic         p_trigger = 1'b0;
    logic         p_req_valid, p_req_data, p_resp_ready;
    logic         p_req_ready = 1'b0;
    logic         p_resp_valid = 1'b0;
    logic [127:0] p_resp_data = '0;
    logic         p_sample_valid, p_sample_first, p_busy;
    logic [63:0]  p_sample_cycle, p_sample_freq, p_sample_delta;
    logic         p_timeout_pulse, p_timeout_err;
    logic [7:0]   p_drop_count;
    longint unsigned p_cyc = 0;
    int           p_stall = 0;
    int           p_wait  = 0;

    cosim_cycle_count_requester #(
        .PERIOD_CYCLES (20),
        .TIMEOUT_CYCLES(1024),
        .DROP_CNT_W    (8)
    ) dut_p (
        .clk          (clk),
        .rst          (p_rst),
        .trigger      (p_trigger),
        .req_valid    (p_req_valid),
        .req_ready    (p_req_ready),
        .req_data     (p_req_data),
        .resp_valid   (p_resp_valid),
        .resp_ready   (p_resp_ready),
        .resp_data    (p_resp_data),
        .sample_valid (p_sample_valid),
        .sample_cycle (p_sample_cycle),
        .sample_freq  (p_sample_freq),
        .sample_delta (p_sample_delta),
        .sample_first (p_sample_first),
        .busy         (p_busy),
        .timeout_pulse(p_timeout_pulse),
        .timeout_err  (p_timeout_err),
        .drop_count   (p_drop_count)
    );

    always @(posedge clk) p_cyc <= p_cyc + 1;

    // Responder: holds req_ready low for 3 cycles of req_valid, accepts on the
    // 4th, answers 4 cycles after the accept with the current bench cycle.
    always @(negedge clk) begin
        p_req_ready  = 1'b0;
        p_resp_valid = 1'b0;
        if (p_rst) begin
            p_stall = 0;
            p_wait  = 0;
        end else if (p_wait > 0) begin
            p_wait = p_wait - 1;
            if (p_wait == 0) begin
                p_resp_valid = 1'b1;
                p_resp_data  = {p_cyc, 64'd50_000_000};
            end
        end else if (p_req_valid) begin
            if (p_stall == 3) begin
                p_req_ready = 1'b1;
                p_stall     = 0;
                p_wait      = 4;
            end else begin
                p_stall = p_stall + 1;
            end
        end
    end

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic comb_sample(input logic [63:0] cyc, input logic [63:0] freq);
        comb_mode   = 1'b1;
        a_resp_data = {cyc, freq};
        a_trigger   = 1'b1;
        tick(1);
        a_trigger   = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_trigger = 1'b0; comb_mode = 1'b1;
        man_req_ready = 1'b0; man_resp_valid = 1'b0; a_resp_data = '0;
        tick(3);
        total++;
        if ({a_req_valid, a_req_data, a_resp_ready, a_sample_valid, a_sample_first,
             a_busy, a_timeout_pulse, a_timeout_err} !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {a_req_valid, a_req_data, a_resp_ready, a_sample_valid, a_sample_first,
                      a_busy, a_timeout_pulse, a_timeout_err});
        end
        total++;
        if ({a_sample_cycle, a_sample_freq, a_sample_delta} !== 192'd0) begin
            bad++;
            $display("FAIL reset_sample: got %h/%h/%h expected 0/0/0",
                     a_sample_cycle, a_sample_freq, a_sample_delta);
        end
        total++;
        if (a_drop_count !== 8'd0) begin
            bad++; $display("FAIL reset_drop: got %0d expected 0", a_drop_count);
        end
        a_rst = 1'b0;
        tick(4);
        total++;
        if (a_resp_ready !== 1'b1 || a_busy !== 1'b0 || a_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got ready=%b busy=%b req=%b expected 1 0 0",
                     a_resp_ready, a_busy, a_req_valid);
        end
    endtask

    task automatic test_first_sample();
        int seen;
        for (int i = 0; i < 20 && a_cyc < 10; i++) tick(1);
        a_resp_data = {64'h64, 64'd100_000_000};
        a_trigger   = 1'b1;
        tick(1);
        a_trigger   = 1'b0;
        total++;
        if (a_req_valid !== 1'b1 || a_busy !== 1'b1 || a_sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_req: got req=%b busy=%b sv=%b expected 1 1 0",
                     a_req_valid, a_busy, a_sample_valid);
        end
        seen = -1;
        for (int i = 0; i < 6 && seen < 0; i++) begin
            if (a_sample_valid === 1'b1) seen = a_cyc;
            else tick(1);
        end
        total++;
        if (seen != 12) begin
            bad++; $display("FAIL first_latency: got cycle %0d expected 12", seen);
        end
        total++;
        if (a_sample_cycle !== 64'h64 || a_sample_freq !== 64'd100_000_000) begin
            bad++;
            $display("FAIL first_data: got %h/%0d expected 64/100000000",
                     a_sample_cycle, a_sample_freq);
        end
        total++;
        if (a_sample_delta !== 64'd0 || a_sample_first !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL first_flags: got delta=%h first=%b busy=%b expected 0 1 0",
                     a_sample_delta, a_sample_first, a_busy);
        end
        tick(1);
        total++;
        if (a_sample_valid !== 1'b0) begin
            bad++; $display("FAIL first_pulse_width: got sv=%b expected 0", a_sample_valid);
        end
    endtask

    task automatic test_second_sample();
        comb_sample(64'h96, 64'd100_000_000);
        total++;
        if (a_sample_valid !== 1'b1 || a_sample_cycle !== 64'h96) begin
            bad++;
            $display("FAIL second_data: got sv=%b cycle=%h expected 1 96",
                     a_sample_valid, a_sample_cycle);
        end
        total++;
        if (a_sample_delta !== 64'h32 || a_sample_first !== 1'b0) begin
            bad++;
            $display("FAIL second_delta: got delta=%h first=%b expected 32 0",
                     a_sample_delta, a_sample_first);
        end
    endtask

    task automatic test_wrap();
        comb_sample(64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        total++;
        if (a_sample_cycle !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            bad++; $display("FAIL wrap_prev: got %h expected fffffffffffffffe", a_sample_cycle);
        end
        tick(1);
        comb_sample(64'h3, 64'd1);
        total++;
        if (a_sample_valid !== 1'b1 || a_sample_delta !== 64'h5) begin
            bad++;
            $display("FAIL wrap_delta: got sv=%b delta=%h expected 1 5",
                     a_sample_valid, a_sample_delta);
        end
    endtask

    task automatic test_back_to_back();
        comb_mode   = 1'b1;
        a_resp_data = {64'h100, 64'd7};
        a_trigger   = 1'b1;
        tick(1);                       // REQ, captured at the next edge
        total++;
        if (a_req_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_req1: got %b expected 1", a_req_valid);
        end
        tick(1);                       // trigger was high during the capture cycle
        a_trigger   = 1'b0;
        total++;
        if (a_sample_valid !== 1'b1 || a_sample_cycle !== 64'h100 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_sample1: got sv=%b cycle=%h busy=%b expected 1 100 0",
                     a_sample_valid, a_sample_cycle, a_busy);
        end
        a_resp_data = {64'h180, 64'd7};
        tick(1);
        total++;
        if (a_req_valid !== 1'b1 || a_sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pending_req: got req=%b sv=%b expected 1 0",
                     a_req_valid, a_sample_valid);
        end
        tick(1);
        total++;
        if (a_sample_valid !== 1'b1 || a_sample_cycle !== 64'h180 || a_sample_delta !== 64'h80) begin
            bad++;
            $display("FAIL b2b_sample2: got sv=%b cycle=%h delta=%h expected 1 180 80",
                     a_sample_valid, a_sample_cycle, a_sample_delta);
        end
        tick(2);
        total++;
        if (a_busy !== 1'b0 || a_sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_extra: got busy=%b sv=%b expected 0 0", a_busy, a_sample_valid);
        end
    endtask

    task automatic test_timeout();
        int early;
        comb_mode = 1'b0; man_req_ready = 1'b1; man_resp_valid = 1'b0;
        a_trigger = 1'b1;
        tick(1);
        a_trigger = 1'b0;
        early = 0;
        for (int k = 1; k <= 8; k++) begin
            if (a_timeout_pulse !== 1'b0 || a_busy !== 1'b1) early++;
            if (k < 8) tick(1);
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL timeout_early: got %0d bad cycles expected 0", early);
        end
        tick(1);
        total++;
        if (a_timeout_pulse !== 1'b1 || a_timeout_err !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fire: got pulse=%b err=%b busy=%b expected 1 1 0",
                     a_timeout_pulse, a_timeout_err, a_busy);
        end
        tick(1);
        total++;
        if (a_timeout_pulse !== 1'b0 || a_timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got pulse=%b err=%b expected 0 1",
                     a_timeout_pulse, a_timeout_err);
        end
        man_req_ready  = 1'b0;
        man_resp_valid = 1'b1;
        a_resp_data    = {64'h300, 64'd9};
        tick(1);
        man_resp_valid = 1'b0;
        total++;
        if (a_drop_count !== 8'd1 || a_sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL late_resp: got drop=%0d sv=%b expected 1 0",
                     a_drop_count, a_sample_valid);
        end
        tick(2);
        total++;
        if (a_sample_valid !== 1'b0 || a_busy !== 1'b0 || a_sample_cycle !== 64'h180) begin
            bad++;
            $display("FAIL late_no_sample: got sv=%b busy=%b cycle=%h expected 0 0 180",
                     a_sample_valid, a_busy, a_sample_cycle);
        end
    endtask

    task automatic test_stale_in_req();
        comb_mode = 1'b0; man_req_ready = 1'b0; man_resp_valid = 1'b0;
        a_trigger = 1'b1;
        tick(1);
        a_trigger = 1'b0;
        total++;
        if (a_req_valid !== 1'b1) begin
            bad++; $display("FAIL stale_req: got %b expected 1", a_req_valid);
        end
        man_resp_valid = 1'b1;
        a_resp_data    = {64'hDEAD, 64'd9};
        tick(1);
        man_resp_valid = 1'b0;
        total++;
        if (a_drop_count !== 8'd2 || a_req_valid !== 1'b1 || a_sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL stale_drop: got drop=%0d req=%b sv=%b expected 2 1 0",
                     a_drop_count, a_req_valid, a_sample_valid);
        end
        tick(1);
        total++;
        if (a_req_valid !== 1'b1) begin
            bad++; $display("FAIL stale_hold: got req=%b expected 1", a_req_valid);
        end
        man_req_ready  = 1'b1;
        man_resp_valid = 1'b1;
        a_resp_data    = {64'h200, 64'd9};
        tick(1);
        man_req_ready  = 1'b0;
        man_resp_valid = 1'b0;
        total++;
        if (a_sample_valid !== 1'b1 || a_sample_cycle !== 64'h200 ||
            a_sample_delta !== 64'h80 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL stale_capture: got sv=%b cycle=%h delta=%h busy=%b expected 1 200 80 0",
                     a_sample_valid, a_sample_cycle, a_sample_delta, a_busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        int spurious;
        comb_mode = 1'b0; man_req_ready = 1'b1; man_resp_valid = 1'b0;
        a_trigger = 1'b1;
        tick(1);                       // REQ
        a_trigger = 1'b0;
        tick(1);                       // WAIT
        a_trigger = 1'b1;
        tick(3);                       // three triggers while waiting
        a_trigger = 1'b0;
        total++;
        if (a_busy !== 1'b1) begin
            bad++; $display("FAIL midwait_busy: got %b expected 1", a_busy);
        end
        a_rst = 1'b1;
        #1;
        total++;
        if ({a_busy, a_req_valid, a_resp_ready, a_timeout_err, a_sample_first} !== 5'b0 ||
            a_drop_count !== 8'd0 || a_sample_cycle !== 64'd0) begin
            bad++;
            $display("FAIL async_clear: got busy=%b req=%b rdy=%b err=%b first=%b drop=%0d cycle=%h expected all 0",
                     a_busy, a_req_valid, a_resp_ready, a_timeout_err, a_sample_first,
                     a_drop_count, a_sample_cycle);
        end
        tick(2);
        a_rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (a_req_valid !== 1'b0 || a_busy !== 1'b0) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++; $display("FAIL pending_cleared: got %0d busy cycles expected 0", spurious);
        end
        comb_sample(64'h500, 64'd11);
        total++;
        if (a_sample_valid !== 1'b1 || a_sample_cycle !== 64'h500 ||
            a_sample_first !== 1'b1 || a_sample_delta !== 64'd0) begin
            bad++;
            $display("FAIL rearm_first: got sv=%b cycle=%h first=%b delta=%h expected 1 500 1 0",
                     a_sample_valid, a_sample_cycle, a_sample_first, a_sample_delta);
        end
    endtask

    task automatic test_periodic();
        bit got;
        int n_samp, stall_cycles, spacing_bad, hold_bad;
        bit prev_stalled;
        p_rst = 1'b1;
        tick(3);
        p_rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick(1);
            if (p_sample_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL periodic_first: got no sample expected one within 80 cycles");
        end
        total++;
        if (p_sample_first !== 1'b1 || p_sample_delta !== 64'd0) begin
            bad++;
            $display("FAIL periodic_first_flags: got first=%b delta=%h expected 1 0",
                     p_sample_first, p_sample_delta);
        end
        n_samp = 0; stall_cycles = 0; spacing_bad = 0; hold_bad = 0; prev_stalled = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (prev_stalled && p_req_valid !== 1'b1) hold_bad++;
            prev_stalled = (p_req_valid === 1'b1) && (p_req_ready === 1'b0);
            if (prev_stalled) stall_cycles++;
            if (p_sample_valid === 1'b1) begin
                n_samp++;
                if (i % 20 != 0) spacing_bad++;
                total++;
                if (p_sample_delta !== 64'd20 || p_sample_first !== 1'b0) begin
                    bad++;
                    $display("FAIL periodic_delta: got delta=%0d first=%b expected 20 0",
                             p_sample_delta, p_sample_first);
                end
            end
        end
        total++;
        if (n_samp != 5 || spacing_bad != 0) begin
            bad++;
            $display("FAIL periodic_count: got %0d samples %0d off-grid expected 5 0",
                     n_samp, spacing_bad);
        end
        total++;
        if (stall_cycles != 15 || hold_bad != 0) begin
            bad++;
            $display("FAIL periodic_hold: got %0d stall cycles %0d withdrawals expected 15 0",
                     stall_cycles, hold_bad);
        end
        total++;
        if (p_drop_count !== 8'd0 || p_timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL periodic_clean: got drop=%0d err=%b expected 0 0",
                     p_drop_count, p_timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_second_sample();
        test_wrap();
        tick(1);
        test_back_to_back();
        test_timeout();
        test_stale_in_req();
        test_reset_mid_wait();
        test_periodic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cosim_cycle_count_requester.md
Name: cosim_cycle_count_requester

Overview:
- Hardware-side initiator for the cycle-count request/response protocol.
- Issues 1-bit trigger requests on a valid/ready channel and accepts 128-bit {cycle, freq} responses, either on demand or periodically.
- Latches the latest sample and computes elapsed cycles since the previous sample.
- Sits between user/debug logic and a cycle-count responder, in simulation or on hardware.

Parameters:
- PERIOD_CYCLES, 0: auto-request interval in cycles; 0 disables periodic requests.
- TIMEOUT_CYCLES, 1024: maximum cycles from request issue to response accept before abort; must be ≥ 1.
- DROP_CNT_W, 8: width of the stale-response counter (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- trigger  in  1  one-cycle request for a sample
- req_valid  out  1  request channel valid
- req_ready  in  1  request channel ready
- req_data  out  1  request payload, constant 0
- resp_valid  in  1  response channel valid
- resp_ready  out  1  response channel ready
- resp_data  in  128  packed {cycle[127:64], freq[63:0]}
- sample_valid  out  1  one-cycle pulse when a new sample is latched
- sample_cycle  out  64  latched cycle value
- sample_freq  out  64  latched frequency (Hz)
- sample_delta  out  64  current cycle minus previous cycle, mod 2^64; 0 on first sample
- sample_first  out  1  high while the latched sample is the first since reset
- busy  out  1  high in REQ or WAIT
- timeout_pulse  out  1  one-cycle pulse on abort
- timeout_err  out  1  sticky timeout flag, cleared only by rst
- drop_count  out  DROP_CNT_W  saturating count of stale responses

Behaviour:
- Reset (async assert, sync deassert internally): FSM=IDLE; all outputs 0; pending=0; period counter=PERIOD_CYCLES; first-sample flag armed.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - req_valid=0, resp_ready=1.
  - Any resp_valid is stale: drop it and increment drop_count (saturate at all-ones).
  - Go to REQ if trigger, pending, or period expiry (counter==1, PERIOD_CYCLES≠0). Clear pending on transition.
- REQ:
  - req_valid=1, resp_ready=1.
  - Responders may tie req_ready to resp_ready and resp_valid to req_valid, so request accept and response arrive in the same cycle.
  - req_ready & resp_valid in the same cycle: capture, go to IDLE.
  - req_ready without resp_valid: go to WAIT.
  - resp_valid without req_ready: stale; drop and count; remain in REQ.
- WAIT:
  - req_valid=0, resp_ready=1.
  - resp_valid: capture, go to IDLE.
- Capture, registered, visible the cycle after the accepting edge:
  - sample_cycle ← resp_data[127:64]; sample_freq ← resp_data[63:0].
  - sample_delta ← first ? 0 : new_cycle − sample_cycle (64-bit wrap).
  - sample_first ← first; clear first flag.
  - sample_valid=1 for exactly one cycle.
- Latency: with a combinational responder, trigger at cycle N → req_valid at N+1 → sample_valid at N+2.
- Timeout:
  - Counter loads on entry to REQ and counts in REQ and WAIT.
  - Reaching TIMEOUT_CYCLES without capture: go to IDLE, pulse timeout_pulse, set timeout_err.
  - A later response arrives in IDLE and counts as stale.
- Trigger while busy: set pending (multiple coalesce to one); served immediately after return to IDLE.
- Trigger in the same cycle as capture: sets pending.
- Period counter:
  - Decrements every cycle in all states; reloads to PERIOD_CYCLES when REQ is entered.
  - Expiry while busy sets pending.
- req_valid, once asserted, is held until req_ready; it is never withdrawn except by timeout or rst.
- rst mid-transaction: immediate IDLE; an in-flight request is abandoned.

Decomposition:
- Package cosim_cycle_count_pkg contains:
  - packed struct resp_t {longint unsigned cycle; longint unsigned freq;}, cycle in the MSBs;
  - state enum {IDLE, REQ, WAIT};
  - localparam RESP_BITS=128.
- Sub-module cosim_cycle_count_period_timer: reloadable down-counter with expiry output, shared by the periodic and timeout logic (two instances).

Test Plan:
- Combinational responder, trigger at cycle 10, resp cycle=0x64, freq=100_000_000 → sample_valid at 12; sample_cycle=0x64; sample_delta=0; sample_first=1.
- Second trigger, resp cycle=0x96 → sample_delta=0x32; sample_first=0.
- Wrap: previous cycle=0xFFFF_FFFF_FFFF_FFFE, new cycle=0x3 → sample_delta=0x5.
- PERIOD_CYCLES=20, responder ready after a 3-cycle req stall and response 4 cycles later → req_valid held through the stall; one sample per 20 cycles; no dropped or duplicate samples.
- TIMEOUT_CYCLES=8, responder never responds → timeout_pulse 8 cycles after REQ entry; timeout_err=1; late response in IDLE → drop_count=1, no sample_valid.
- Three triggers while WAIT, then rst asserted mid-WAIT → outputs cleared asynchronously; pending cleared; after release, no request issued until the next trigger.
